reg_file_banked: RTL and testbench
==================================

Name: reg_file_banked

Overview:
Parametrised, multi-bank CPU register file. It replaces the single-bank, single-read-port register file. It provides:
- one write port and two independent combinational read ports into the currently active bank;
- a registered bank-select for fast interrupt context switching;
- a hardware bank-clear engine that zeroes any bank, one register per cycle, with a busy/done handshake.

It sits between the CPU control unit/decoder and the ALU/operand muxes.

Parameters:
DATA_W, 8, register width in bits (>=1)
NUM_REGS, 8, registers per bank (power of two, >=2)
NUM_BANKS, 2, number of banks (power of two, >=1)
AW, $clog2(NUM_REGS), derived register address width; not overridden
BW, max(1,$clog2(NUM_BANKS)), derived bank index width; not overridden

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rf_write_en  in  1  write strobe, active bank
rf_write_addr  in  AW  write register index
rf_in  in  DATA_W  write data
rA_addr  in  AW  read port A index
rB_addr  in  AW  read port B index
rA  out  DATA_W  read port A data, active bank
rB  out  DATA_W  read port B data, active bank
bank_sel_req  in  1  single-cycle request to change active bank
bank_sel  in  BW  requested bank index
bank_active  out  BW  current active bank
clr_req  in  1  start clear of bank clr_bank
clr_bank  in  BW  bank to clear
clr_busy  out  1  clear engine sweeping
clr_done  out  1  one-cycle pulse, clear complete

Behaviour:
- Reset (async assert, sync-safe deassert by system):
  - all NUM_BANKS*NUM_REGS registers = 0;
  - bank_active = 0;
  - FSM = IDLE; clr_busy = 0; clr_done = 0;
  - rA/rB read 0.
- Reads: rA = bank[bank_active][rA_addr]; rB likewise. Purely combinational, 0-cycle latency.
- Writes: when rf_write_en is high, bank[bank_active][rf_write_addr] <= rf_in at the edge. Visible on reads the following cycle (see optional feature).
- Bank switch:
  - When bank_sel_req is high and bank_sel < NUM_BANKS, bank_active <= bank_sel at the edge.
  - A write in the same cycle targets the OLD bank.
  - If bank_sel >= NUM_BANKS, the request is ignored.
  - Reads reflect the new bank from the next cycle.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: on clr_req (and clr_bank < NUM_BANKS), latch clr_bank into cbank, set ptr=0, go to CLEAR. An invalid clr_bank is ignored.
  - CLEAR: clr_busy=1. Each cycle bank[cbank][ptr] <= 0 and ptr++. When ptr==NUM_REGS-1, after zeroing, go to DONE.
  - DONE: clr_done=1 for exactly one cycle, clr_busy=0, then IDLE.
  - clr_req outside IDLE is ignored (not queued).
  - Latency: request seen at edge 0; clr_busy high for NUM_REGS cycles; clr_done high in cycle NUM_REGS+1.
- Simultaneous events:
  - User write and clear hit the same bank and register in the same cycle: the user write wins, and ptr still advances.
  - User writes to registers already cleared persist. Writes to registers not yet swept are later zeroed.
  - A bank switch during CLEAR does not affect cbank.
  - Reads of a bank being cleared show progressive zeroing.
- Reset mid-clear: the FSM aborts to IDLE and all registers become 0. No clr_done pulse is produced.
- Address inputs are always in range by width; no wrap handling is needed.

Optional Feature:
Macro: RF_BYPASS_EN
- Defined: write-through forwarding on both read ports.
  - If rf_write_en is high, there is no bank_sel change pending ambiguity, and rX_addr==rf_write_addr, then rX = rf_in in the same cycle.
  - Forwarding uses the current (pre-switch) bank_active.
  - The clear engine's zero writes are NOT forwarded.
- Undefined: no forwarding; reads return stored values only. A write is visible one cycle later.

Test Plan:
- Reset then read all addresses, banks 0..NUM_BANKS-1 via switch -> every rA/rB = 0x00, bank_active=0.
- Write bank0 r3=0xA5, same-cycle read rA_addr=3 -> 0x00 (0xA5 with RF_BYPASS_EN); next cycle rA=0xA5, rB_addr=3 rB=0xA5.
- Write r2=0x11 in same cycle as bank_sel_req/bank_sel=1 -> next cycle rA(r2)=0x00; switch back to 0 -> r2=0x11.
- Fill bank1 with 0xFF, clr_req clr_bank=1 -> clr_busy high exactly 8 cycles, clr_done one pulse at cycle 9, bank1 all 0x00, bank0 untouched.
- During clear of active bank0, write r0=0x5C after ptr passed 0 and r7=0x33 before ptr reaches 7 -> r0=0x5C, r7=0x00 at done; a write colliding with ptr keeps the write value.
- Assert rst_n=0 at cycle 4 of a clear -> clr_busy=0 immediately, no clr_done, all registers 0; new clr_req after release is accepted.

Source files
------------

// File: rtl/reg_file_banked_if.sv
// Bus between the CPU control/decode side (master) and the banked register file (slave).
// Carries the write port, both read ports, bank selection and the bank-clear handshake.
interface reg_file_banked_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 8,
  parameter int NUM_BANKS = 2
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic              rf_write_en;
  logic [AW-1:0]     rf_write_addr;
  logic [DATA_W-1:0] rf_in;
  logic [AW-1:0]     rA_addr;
  logic [AW-1:0]     rB_addr;
  logic [DATA_W-1:0] rA;
  logic [DATA_W-1:0] rB;
  logic              bank_sel_req;
  logic [BW-1:0]     bank_sel;
  logic [BW-1:0]     bank_active;
  logic              clr_req;
  logic [BW-1:0]     clr_bank;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output rf_write_en, rf_write_addr, rf_in, rA_addr, rB_addr,
           bank_sel_req, bank_sel, clr_req, clr_bank,
    input  rA, rB, bank_active, clr_busy, clr_done
  );

  modport slave (
    input  rf_write_en, rf_write_addr, rf_in, rA_addr, rB_addr,
           bank_sel_req, bank_sel, clr_req, clr_bank,
    output rA, rB, bank_active, clr_busy, clr_done
  );
endinterface

// File: rtl/reg_file_banked.sv
// Multi-bank register file: one write port, two combinational read ports, registered bank
// select and a one-register-per-cycle bank clear engine. Define RF_BYPASS_EN for write-through reads.
module reg_file_banked #(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 8,
  parameter int NUM_BANKS = 2,
  localparam int AW = $clog2(NUM_REGS),
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input logic              clk,
  input logic              rst_n,
  reg_file_banked_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [NUM_BANKS][NUM_REGS];

  logic [BW-1:0]     bank_active_q;
  state_t            state_q, state_d;
  logic [BW-1:0]     cbank_q, cbank_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              clr_busy_c, clr_done_c;
  logic [DATA_W-1:0] rd_a, rd_b;

  function automatic logic bank_ok(input logic [BW-1:0] b);
    return (int'(b) < NUM_BANKS);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_active_q <= '0;
    end else if (bus.bank_sel_req && bank_ok(bus.bank_sel)) begin
      bank_active_q <= bus.bank_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cbank_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cbank_q <= cbank_d;
      ptr_q   <= ptr_d;
    end
  end

  // Requests arriving while a sweep is in flight are dropped rather than queued.
  always_comb begin
    state_d    = state_q;
    cbank_d    = cbank_q;
    ptr_d      = ptr_q;
    clr_busy_c = 1'b0;
    clr_done_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_req && bank_ok(bus.clr_bank)) begin
          state_d = S_CLEAR;
          cbank_d = bus.clr_bank;
          ptr_d   = '0;
        end
      end
      S_CLEAR: begin
        clr_busy_c = 1'b1;
        ptr_d      = ptr_q + AW'(1);
        if (ptr_q == AW'(NUM_REGS - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        clr_done_c = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The user write is scheduled after the sweep's zero write, so it wins on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else begin
      if (state_q == S_CLEAR) begin
        mem[cbank_q][ptr_q] <= '0;
      end
      if (bus.rf_write_en) begin
        mem[bank_active_q][bus.rf_write_addr] <= bus.rf_in;
      end
    end
  end

  always_comb begin
    rd_a = mem[bank_active_q][bus.rA_addr];
    rd_b = mem[bank_active_q][bus.rB_addr];
`ifdef RF_BYPASS_EN
    // Forward against the pre-switch bank, which is also the bank the write lands in.
    if (bus.rf_write_en && (bus.rA_addr == bus.rf_write_addr)) begin
      rd_a = bus.rf_in;
    end
    if (bus.rf_write_en && (bus.rB_addr == bus.rf_write_addr)) begin
      rd_b = bus.rf_in;
    end
`endif
  end

  assign bus.rA          = rd_a;
  assign bus.rB          = rd_b;
  assign bus.bank_active = bank_active_q;
  assign bus.clr_busy    = clr_busy_c;
  assign bus.clr_done    = clr_done_c;

endmodule

// File: tb/tb_reg_file_banked.sv
// Scoreboard bench for reg_file_banked: stimulus queues expected values tagged with the cycle
// they are due in; a negedge monitor pops and compares them and tracks every clr_done pulse.
module tb_reg_file_banked;
  localparam int DATA_W    = 8;
  localparam int NUM_REGS  = 8;
  localparam int NUM_BANKS = 2;
  localparam int AW        = $clog2(NUM_REGS);
  localparam int BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int NR        = NUM_REGS;

  localparam int SEL_A    = 0;
  localparam int SEL_B    = 1;
  localparam int SEL_BANK = 2;
  localparam int SEL_BUSY = 3;
  localparam int SEL_DONE = 4;

`ifdef RF_BYPASS_EN
  localparam logic [31:0] SAME_CYCLE_A5 = 32'hA5;
`else
  localparam logic [31:0] SAME_CYCLE_A5 = 32'h00;
`endif

  typedef struct {
    int          id;
    int          sel;
    logic [31:0] val;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   next_id = 0;

  exp_t exp_q[$];
  int   done_q[$];

  logic [7:0] zero_v [NR];
  logic [7:0] pat_v  [NR];

  reg_file_banked_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_BANKS(NUM_BANKS)) bus ();

  reg_file_banked #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_BANKS(NUM_BANKS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sel_name(input int sel);
    case (sel)
      SEL_A:    return "rA";
      SEL_B:    return "rB";
      SEL_BANK: return "bank_active";
      SEL_BUSY: return "clr_busy";
      default:  return "clr_done";
    endcase
  endfunction

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      SEL_A:    return 32'(bus.rA);
      SEL_B:    return 32'(bus.rB);
      SEL_BANK: return 32'(bus.bank_active);
      SEL_BUSY: return 32'(bus.clr_busy);
      default:  return 32'(bus.clr_done);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due <= cyc) begin
        checks++;
        if (exp_q[i].due != cyc) begin
          errors++;
          $display("FAIL %s#%0d missed: actual=unchecked at cycle %0d required=%0h due cycle %0d",
                   sel_name(exp_q[i].sel), exp_q[i].id, cyc, exp_q[i].val, exp_q[i].due);
        end else if (pick(exp_q[i].sel) !== exp_q[i].val) begin
          errors++;
          $display("FAIL %s#%0d cycle %0d: actual=%0h required=%0h",
                   sel_name(exp_q[i].sel), exp_q[i].id, cyc, pick(exp_q[i].sel), exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
    if (bus.clr_done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL clr_done_pulse: actual=pulse at cycle %0d required=no pulse", cyc);
      end else begin
        int want;
        want = done_q.pop_front();
        if (want != cyc) begin
          errors++;
          $display("FAIL clr_done_time: actual=cycle %0d required=cycle %0d", cyc, want);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int sel, input logic [31:0] v, input int due);
    exp_t e;
    e.id  = next_id;
    e.sel = sel;
    e.val = v;
    e.due = due;
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic switch_bank(input int b);
    bus.bank_sel_req = 1'b1;
    bus.bank_sel     = BW'(b);
    tick();
    bus.bank_sel_req = 1'b0;
    expect_at(SEL_BANK, 32'(b), cyc);
  endtask

  task automatic check_regs(input logic [7:0] v [NR]);
    for (int a = 0; a < NR; a++) begin
      bus.rA_addr = AW'(a);
      bus.rB_addr = AW'(NR - 1 - a);
      expect_at(SEL_A, 32'(v[a]), cyc);
      expect_at(SEL_B, 32'(v[NR - 1 - a]), cyc);
      tick();
    end
  endtask

  task automatic write_reg(input int addr, input logic [7:0] val);
    bus.rf_write_en   = 1'b1;
    bus.rf_write_addr = AW'(addr);
    bus.rf_in         = val;
    tick();
    bus.rf_write_en   = 1'b0;
  endtask

  initial begin
    int k;
    rst_n             = 1'b0;
    bus.rf_write_en   = 1'b0;
    bus.rf_write_addr = '0;
    bus.rf_in         = '0;
    bus.rA_addr       = '0;
    bus.rB_addr       = '0;
    bus.bank_sel_req  = 1'b0;
    bus.bank_sel      = '0;
    bus.clr_req       = 1'b0;
    bus.clr_bank      = '0;
    for (int i = 0; i < NR; i++) zero_v[i] = 8'h00;

    repeat (2) tick();
    expect_at(SEL_A, 32'h0, cyc);
    expect_at(SEL_BANK, 32'h0, cyc);
    expect_at(SEL_BUSY, 32'h0, cyc);
    expect_at(SEL_DONE, 32'h0, cyc);
    tick();
    rst_n = 1'b1;

    // Every register of every bank reads zero after reset.
    expect_at(SEL_BANK, 32'h0, cyc);
    check_regs(zero_v);
    switch_bank(1);
    check_regs(zero_v);
    switch_bank(0);

    // Write r3, read same cycle and next cycle.
    bus.rA_addr = AW'(3);
    bus.rf_write_en = 1'b1;
    bus.rf_write_addr = AW'(3);
    bus.rf_in = 8'hA5;
    expect_at(SEL_A, SAME_CYCLE_A5, cyc);
    tick();
    bus.rf_write_en = 1'b0;
    bus.rB_addr = AW'(3);
    expect_at(SEL_A, 32'hA5, cyc);
    expect_at(SEL_B, 32'hA5, cyc);
    tick();

    // Write coinciding with a bank switch lands in the old bank.
    bus.rf_write_en = 1'b1;
    bus.rf_write_addr = AW'(2);
    bus.rf_in = 8'h11;
    bus.bank_sel_req = 1'b1;
    bus.bank_sel = BW'(1);
    bus.rA_addr = AW'(2);
    tick();
    bus.rf_write_en = 1'b0;
    bus.bank_sel_req = 1'b0;
    expect_at(SEL_A, 32'h00, cyc);
    expect_at(SEL_BANK, 32'h1, cyc);
    switch_bank(0);
    expect_at(SEL_A, 32'h11, cyc);
    tick();

    // Fill bank1, then clear it while bank0 is active.
    switch_bank(1);
    for (int r = 0; r < NR; r++) write_reg(r, 8'hFF);
    switch_bank(0);
    k = cyc;
    bus.clr_req = 1'b1;
    bus.clr_bank = BW'(1);
    expect_at(SEL_BUSY, 32'h0, k);
    expect_at(SEL_BUSY, 32'h1, k + 1);
    expect_at(SEL_BUSY, 32'h1, k + 8);
    expect_at(SEL_DONE, 32'h0, k + 8);
    expect_at(SEL_BUSY, 32'h0, k + 9);
    expect_at(SEL_BUSY, 32'h0, k + 10);
    expect_at(SEL_DONE, 32'h0, k + 10);
    done_q.push_back(k + 9);
    tick();
    bus.clr_req = 1'b0;
    tick();
    bus.clr_req = 1'b1;
    bus.clr_bank = BW'(0);
    tick();
    bus.clr_req = 1'b0;
    tick();
    bus.bank_sel_req = 1'b1;
    bus.bank_sel = BW'(1);
    tick();
    bus.bank_sel = BW'(0);
    bus.rA_addr = AW'(7);
    bus.rB_addr = AW'(0);
    expect_at(SEL_BANK, 32'h1, cyc);
    expect_at(SEL_A, 32'hFF, cyc);
    expect_at(SEL_B, 32'h00, cyc);
    tick();
    bus.bank_sel_req = 1'b0;
    while (cyc < k + 11) tick();
    for (int i = 0; i < NR; i++) pat_v[i] = 8'h00;
    pat_v[2] = 8'h11;
    pat_v[3] = 8'hA5;
    check_regs(pat_v);
    switch_bank(1);
    check_regs(zero_v);
    switch_bank(0);

    // Clear the active bank with user writes racing the sweep pointer.
    k = cyc;
    bus.clr_req = 1'b1;
    bus.clr_bank = BW'(0);
    bus.rA_addr = AW'(3);
    bus.rB_addr = AW'(7);
    expect_at(SEL_A, 32'hA5, k);
    expect_at(SEL_A, 32'hA5, k + 4);
    expect_at(SEL_A, 32'h00, k + 5);
    expect_at(SEL_B, 32'h33, k + 5);
    expect_at(SEL_B, 32'h00, k + 9);
    done_q.push_back(k + 9);
    tick();
    bus.clr_req = 1'b0;
    while (cyc < k + 11) begin
      bus.rf_write_en = 1'b0;
      if (cyc == k + 3) begin
        bus.rf_write_en = 1'b1; bus.rf_write_addr = AW'(0); bus.rf_in = 8'h5C;
      end else if (cyc == k + 4) begin
        bus.rf_write_en = 1'b1; bus.rf_write_addr = AW'(7); bus.rf_in = 8'h33;
      end else if (cyc == k + 6) begin
        bus.rf_write_en = 1'b1; bus.rf_write_addr = AW'(5); bus.rf_in = 8'h77;
      end
      tick();
    end
    bus.rf_write_en = 1'b0;
    for (int i = 0; i < NR; i++) pat_v[i] = 8'h00;
    pat_v[0] = 8'h5C;
    pat_v[5] = 8'h77;
    check_regs(pat_v);

    // Reset in the fourth busy cycle of a clear aborts it without a done pulse.
    switch_bank(1);
    write_reg(1, 8'h42);
    k = cyc;
    bus.clr_req = 1'b1;
    bus.clr_bank = BW'(0);
    expect_at(SEL_BUSY, 32'h1, k + 1);
    tick();
    bus.clr_req = 1'b0;
    while (cyc < k + 4) tick();
    rst_n = 1'b0;
    expect_at(SEL_BUSY, 32'h0, cyc);
    expect_at(SEL_DONE, 32'h0, cyc);
    expect_at(SEL_BANK, 32'h0, cyc);
    tick();
    tick();
    rst_n = 1'b1;
    check_regs(zero_v);
    switch_bank(1);
    check_regs(zero_v);
    k = cyc;
    bus.clr_req = 1'b1;
    bus.clr_bank = BW'(1);
    expect_at(SEL_BUSY, 32'h1, k + 1);
    expect_at(SEL_BUSY, 32'h0, k + 9);
    done_q.push_back(k + 9);
    tick();
    bus.clr_req = 1'b0;
    while (cyc < k + 11) tick();

    for (int n = 0; n < 40 && (exp_q.size() != 0 || done_q.size() != 0); n++) tick();
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s#%0d never checked: actual=none required=%0h", sel_name(e.sel), e.id, e.val);
    end
    while (done_q.size() != 0) begin
      int w;
      w = done_q.pop_front();
      checks++;
      errors++;
      $display("FAIL clr_done_missing: actual=no pulse required=pulse at cycle %0d", w);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
